// File: rtl/sdes_iterative_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sdes_iterative_core
//  Purpose  : Iterative Simplified-DES block core. It does one Feistel round
//             per clock, with a configurable round count. It has
//             valid/ready handshakes on both the input and output sides.
//  Revision : 1.0 - initial release
// ============================================================================
module sdes_iterative_core #(
    parameter int NUM_ROUNDS = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_mode,
    input  logic [9:0]  i_key,
    input  logic [7:0]  i_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [7:0]  o_data,
    output logic        o_busy
);

    // The counter can reach NUM_ROUNDS after the final round without wrapping.
    localparam int CW = $clog2(NUM_ROUNDS) + 1;

    // S-box tables. The index is {row, col}, with 2 bits per entry and entry 0 at the LSB.
    localparam logic [31:0] c_S0_TBL = {2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0,
                                        2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1};
    localparam logic [31:0] c_S1_TBL = {2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
                                        2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Permutations. Bit position p (1 = MSB) of an N-bit word is x[N-p].
    function automatic logic [7:0] f_ip(input logic [7:0] x);
        return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
    endfunction

    function automatic logic [7:0] f_ip_inv(input logic [7:0] x);
        return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
    endfunction

    function automatic logic [9:0] f_p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] f_p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [4:0] f_rotl5(input logic [4:0] x, input int n);
        case (n % 5)
            1:       return {x[3:0], x[4]};
            2:       return {x[2:0], x[4:3]};
            3:       return {x[1:0], x[4:2]};
            4:       return {x[0],   x[4:1]};
            default: return x;
        endcase
    endfunction

    function automatic logic [1:0] f_sbox(input logic [31:0] tbl, input logic [3:0] v);
        logic [3:0] idx;
        idx = {v[3], v[0], v[2], v[1]};
        return tbl[{idx, 1'b0} +: 2];
    endfunction

    // The round function F(R, K): E/P, key mix, S-boxes and P4.
    function automatic logic [3:0] f_fk(input logic [3:0] r, input logic [7:0] k);
        logic [7:0] e;
        logic [3:0] s;
        e = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
        s = {f_sbox(c_S0_TBL, e[7:4]), f_sbox(c_S1_TBL, e[3:0])};
        return {s[2], s[0], s[1], s[3]};
    endfunction

    state_t          r_state;
    state_t          w_next_state;
    logic            r_armed;
    logic            r_mode;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_blk;
    logic [7:0]      r_out;
    logic [7:0]      r_keys [NUM_ROUNDS];
    logic [7:0]      w_keys [NUM_ROUNDS];
    logic [9:0]      w_p10;
    logic [CW-1:0]   w_idx;
    logic [7:0]      w_rkey;
    logic [3:0]      w_left_new;
    logic            w_last;
    logic            w_in_ready;
    logic            w_accept;

    assign w_p10      = f_p10(i_key);
    assign w_in_ready = r_armed && ((r_state == S_IDLE) || ((r_state == S_DONE) && i_out_ready));
    assign w_accept   = i_in_valid && w_in_ready;
    assign w_last     = (r_cnt == CW'(NUM_ROUNDS - 1));
    assign w_idx      = r_mode ? (CW'(NUM_ROUNDS - 1) - r_cnt) : r_cnt;
    assign w_left_new = r_blk[7:4] ^ f_fk(r_blk[3:0], w_rkey);

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = (r_state == S_DONE);
    assign o_busy      = (r_state == S_ROUND);
    assign o_data      = r_out;

    // Derive the whole key schedule from the raw key (cumulative shift 2k+1).
    always_comb begin
        for (int k = 0; k < NUM_ROUNDS; k++) begin
            w_keys[k] = f_p8({f_rotl5(w_p10[9:5], 2 * k + 1), f_rotl5(w_p10[4:0], 2 * k + 1)});
        end
    end

    // Select this round's key; decryption walks the schedule backwards.
    always_comb begin
        w_rkey = '0;
        for (int k = 0; k < NUM_ROUNDS; k++) begin
            if (w_idx == CW'(k)) begin
                w_rkey = r_keys[k];
            end
        end
    end

    // State register, plus a flag that holds off o_in_ready until the first edge after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_armed <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_ROUND;
                end
            end
            S_ROUND: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_next_state = S_ROUND;
                end else if (i_out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: load on accept, then one round per cycle. Swap after every round except the last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode <= 1'b0;
            r_cnt  <= '0;
            r_blk  <= '0;
            r_out  <= '0;
            for (int k = 0; k < NUM_ROUNDS; k++) begin
                r_keys[k] <= '0;
            end
        end else if (w_accept) begin
            r_mode <= i_mode;
            r_cnt  <= '0;
            r_blk  <= f_ip(i_data);
            for (int k = 0; k < NUM_ROUNDS; k++) begin
                r_keys[k] <= w_keys[k];
            end
        end else if (r_state == S_ROUND) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_blk <= {w_left_new, r_blk[3:0]};
                r_out <= f_ip_inv({w_left_new, r_blk[3:0]});
            end else begin
                r_blk <= {r_blk[3:0], w_left_new};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdes_iterative_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sdes_iterative_core
//  Purpose  : Directed self-checking bench for sdes_iterative_core. Instance
//             0 uses NUM_ROUNDS=2, instance 1 uses 4 and instance 2 uses 1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdes_iterative_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic [9:0] key = '0;
    logic [7:0] din = '0;
    logic       out_ready = 1'b0;
    logic [2:0] in_valid = '0;
    logic [2:0] ir;
    logic [2:0] ov;
    logic [2:0] bz;
    logic [7:0] od [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdes_iterative_core #(.NUM_ROUNDS(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(ir[0]),
        .i_mode(mode), .i_key(key), .i_data(din), .o_out_valid(ov[0]),
        .i_out_ready(out_ready), .o_data(od[0]), .o_busy(bz[0]));

    sdes_iterative_core #(.NUM_ROUNDS(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(ir[1]),
        .i_mode(mode), .i_key(key), .i_data(din), .o_out_valid(ov[1]),
        .i_out_ready(out_ready), .o_data(od[1]), .o_busy(bz[1]));

    sdes_iterative_core #(.NUM_ROUNDS(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[2]), .o_in_ready(ir[2]),
        .i_mode(mode), .i_key(key), .i_data(din), .o_out_valid(ov[2]),
        .i_out_ready(out_ready), .o_data(od[2]), .o_busy(bz[2]));

    // Offer one block to instance d, wait for the result, then consume it.
    task automatic run_block(input int d, input logic m, input logic [9:0] k,
                             input logic [7:0] x, output logic [7:0] y, output int lat);
        @(negedge clk);
        mode = m; key = k; din = x; in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        lat = 0;
        while (!ov[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        y = od[d];
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ir[0] !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", ir[0]); end
        n_cmp++; if (ov[0] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", ov[0]); end
        n_cmp++; if (bz[0] !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bz[0]); end
        n_cmp++; if (od[0] !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", od[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (ir[0] !== 1'b0) begin n_err++; $display("FAIL ready_before_edge got %b want 0", ir[0]); end
        @(posedge clk); #1;
        n_cmp++; if (ir !== 3'b111) begin n_err++; $display("FAIL ready_after_release got %b want 111", ir); end
    endtask

    task automatic test_vectors();
        logic [7:0] y;
        int lat;
        run_block(0, 1'b0, 10'b1010000010, 8'b10010111, y, lat);
        n_cmp++; if (y !== 8'b00111000) begin n_err++; $display("FAIL enc_std got %b want 00111000", y); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL enc_std_latency got %0d want 2", lat); end
        n_cmp++; if (u_dut2.r_keys[0] !== 8'b10100100) begin n_err++; $display("FAIL k1 got %b want 10100100", u_dut2.r_keys[0]); end
        n_cmp++; if (u_dut2.r_keys[1] !== 8'b01000011) begin n_err++; $display("FAIL k2 got %b want 01000011", u_dut2.r_keys[1]); end
        run_block(0, 1'b1, 10'b1010000010, 8'b00111000, y, lat);
        n_cmp++; if (y !== 8'b10010111) begin n_err++; $display("FAIL dec_std got %b want 10010111", y); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL dec_std_latency got %0d want 2", lat); end
        run_block(0, 1'b0, 10'h000, 8'h00, y, lat);
        n_cmp++; if (y !== 8'hF0) begin n_err++; $display("FAIL enc_zero got %h want f0", y); end
        run_block(0, 1'b1, 10'h000, 8'hF0, y, lat);
        n_cmp++; if (y !== 8'h00) begin n_err++; $display("FAIL dec_zero got %h want 00", y); end
    endtask

    task automatic test_hold();
        int w;
        @(negedge clk);
        mode = 1'b0; key = 10'b1010000010; din = 8'b10010111; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bz[0] !== 1'b1) begin n_err++; $display("FAIL busy_in_round got %b want 1", bz[0]); end
        n_cmp++; if (ir[0] !== 1'b0) begin n_err++; $display("FAIL ready_in_round got %b want 0", ir[0]); end
        w = 0;
        while (!ov[0] && w < 20) begin @(posedge clk); #1; w++; end
        n_cmp++; if (ov[0] !== 1'b1) begin n_err++; $display("FAIL hold_reach_done got %b want 1", ov[0]); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            din = 8'($urandom); key = 10'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (od[0] !== 8'b00111000 || ir[0] !== 1'b0 || ov[0] !== 1'b1 || bz[0] !== 1'b0) begin
                n_err++;
                $display("FAIL hold_cycle%0d got data=%h ready=%b valid=%b busy=%b want 38/0/1/0", c, od[0], ir[0], ov[0], bz[0]);
            end
        end
        @(negedge clk);
        in_valid[0] = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (ov[0] !== 1'b0 || bz[0] !== 1'b0) begin n_err++; $display("FAIL hold_release got valid=%b busy=%b want 0/0", ov[0], bz[0]); end
        n_cmp++; if (ir[0] !== 1'b1) begin n_err++; $display("FAIL idle_ready got %b want 1", ir[0]); end
    endtask

    task automatic test_back_to_back();
        logic       m_v [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [9:0] k_v [4] = '{10'b1010000010, 10'h000, 10'b1010000010, 10'h000};
        logic [7:0] d_v [4] = '{8'h97, 8'h00, 8'h38, 8'hF0};
        logic [7:0] e_v [4] = '{8'h38, 8'hF0, 8'h97, 8'h00};
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int last_hs = 0;
        out_ready = 1'b1;
        while (got < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (ov[0]) begin
                n_cmp++; if (od[0] !== e_v[got]) begin n_err++; $display("FAIL b2b_data%0d got %h want %h", got, od[0], e_v[got]); end
                if (got > 0) begin
                    n_cmp++; if (cyc - last_hs !== 3) begin n_err++; $display("FAIL b2b_spacing%0d got %0d want 3", got, cyc - last_hs); end
                end
                last_hs = cyc;
                got++;
            end
            if (idx < 4) begin
                mode = m_v[idx]; key = k_v[idx]; din = d_v[idx]; in_valid[0] = 1'b1;
                if (ir[0]) idx++;
            end else begin
                in_valid[0] = 1'b0;
            end
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (got !== 4) begin n_err++; $display("FAIL b2b_count got %0d want 4", got); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] y;
        int lat;
        int w;
        int seen;
        run_block(0, 1'b0, 10'b1010000010, 8'h97, y, lat);
        @(negedge clk);
        mode = 1'b0; key = 10'h000; din = 8'h00; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        n_cmp++; if (bz[0] !== 1'b1) begin n_err++; $display("FAIL mid_round_busy got %b want 1", bz[0]); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || od[0] !== 8'h00) begin
            n_err++; $display("FAIL mid_round_reset got valid=%b busy=%b data=%h want 0/0/00", ov[0], bz[0], od[0]);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ov[0]) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL discard_after_reset got %0d valid cycles want 0", seen); end
        // Reset while a result is waiting in DONE.
        @(negedge clk);
        mode = 1'b0; key = 10'b1010000010; din = 8'h97; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        w = 0;
        while (!ov[0] && w < 20) begin @(posedge clk); #1; w++; end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ov[0] !== 1'b0 || od[0] !== 8'h00) begin
            n_err++; $display("FAIL mid_done_reset got valid=%b data=%h want 0/00", ov[0], od[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(0, 1'b0, 10'b1010000010, 8'h97, y, lat);
        n_cmp++; if (y !== 8'h38 || lat !== 2) begin n_err++; $display("FAIL post_reset_block got %h lat %0d want 38 lat 2", y, lat); end
    endtask

    task automatic test_rounds1();
        logic [7:0] y;
        int lat;
        run_block(2, 1'b0, 10'h000, 8'h00, y, lat);
        n_cmp++; if (y !== 8'h40) begin n_err++; $display("FAIL r1_enc got %h want 40", y); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL r1_latency got %0d want 1", lat); end
        run_block(2, 1'b1, 10'h000, 8'h40, y, lat);
        n_cmp++; if (y !== 8'h00) begin n_err++; $display("FAIL r1_dec got %h want 00", y); end
    endtask

    task automatic test_roundtrip4();
        logic [7:0] c;
        logic [7:0] p;
        logic [9:0] k;
        int lat;
        int lat2;
        for (int ki = 0; ki < 16; ki++) begin
            k = 10'($urandom_range(0, 1023));
            for (int x = 0; x < 256; x++) begin
                run_block(1, 1'b0, k, 8'(x), c, lat);
                run_block(1, 1'b1, k, c, p, lat2);
                n_cmp++;
                if (p !== 8'(x) || lat !== 4 || lat2 !== 4) begin
                    n_err++;
                    $display("FAIL rt4 key=%h got %h lat %0d/%0d want %h lat 4/4", k, p, lat, lat2, 8'(x));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_rounds1();
        test_roundtrip4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
